// File: rtl/thirty_two_to_five_encoder.sv
// Purpose: 32-request pending register with a 5-bit index encoder; lowest index wins, or round-robin with ENCODER_ROUND_ROBIN_EN.
// Latency: req_bits pulse -> out_valid two cycles later; at most one grant every two cycles.
// Backpressure: a presented grant is held until out_ready; its pending bit clears on that handshake.
module thirty_two_to_five_encoder (
   input  logic        clk,
   input  logic        reset,
   input  logic        enabled,
   input  logic [31:0] req_bits,
   input  logic        out_ready,
   output logic [4:0]  select_bits,
   output logic        out_valid,
   output logic [31:0] pending
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [0:0]  state;
   logic [31:0] clear_mask;
   logic [31:0] pending_next;
   logic [4:0]  winner;
   logic        found;
   logic        handshake;

   assign handshake = (state == PRESENT) && out_ready;

   // A request arriving in the handshake cycle re-sets the bit being cleared.
   always_comb begin
      clear_mask = 32'h0;
      if (handshake) begin
         clear_mask = 32'd1 << select_bits;
      end
      pending_next = pending & ~clear_mask;
      if (enabled) begin
         pending_next = pending_next | req_bits;
      end
   end

`ifdef ENCODER_ROUND_ROBIN_EN
   logic [4:0] rr_ptr;
   logic [4:0] idx;

   // Search starts one past the last granted index and wraps 31 -> 0.
   always_comb begin
      winner = 5'd0;
      found  = 1'b0;
      idx    = 5'd0;
      for (int i = 0; i < 32; i++) begin
         idx = rr_ptr + 5'(i);
         if (!found && pending[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= 5'd0;
      end else if (handshake) begin
         rr_ptr <= select_bits + 5'd1;
      end
   end
`else
   always_comb begin
      winner = 5'd0;
      found  = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (!found && pending[i]) begin
            winner = 5'(i);
            found  = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         pending     <= 32'h0;
         select_bits <= 5'd0;
         out_valid   <= 1'b0;
      end else begin
         pending <= pending_next;
         if (state == IDLE) begin
            if (enabled && found) begin
               select_bits <= winner;
               out_valid   <= 1'b1;
               state       <= PRESENT;
            end
         end else begin
            if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_thirty_two_to_five_encoder.sv
// Directed bench for thirty_two_to_five_encoder; fixed-priority expectations unless ENCODER_ROUND_ROBIN_EN is defined.
module tb_thirty_two_to_five_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        enabled;
   logic [31:0] req_bits;
   logic        out_ready;
   logic [4:0]  select_bits;
   logic        out_valid;
   logic [31:0] pending;

   int checks = 0;
   int errors = 0;

   thirty_two_to_five_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .enabled     (enabled),
      .req_bits    (req_bits),
      .out_ready   (out_ready),
      .select_bits (select_bits),
      .out_valid   (out_valid),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enabled = 1'b1; req_bits = 32'hFFFF_FFFF; out_ready = 1'b1;
      step();
      step();
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL reset_pending got=%h exp=%h", pending, 32'h0);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (select_bits !== 5'd0) begin
         errors++; $display("FAIL reset_select got=%0d exp=0", select_bits);
      end
      reset = 1'b0; req_bits = 32'h0; out_ready = 1'b0;
   endtask

   task automatic test_single();
      req_bits = 32'h0000_0010;
      step();
      req_bits = 32'h0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL single_early_valid got=%b exp=0", out_valid);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd4) begin
         errors++; $display("FAIL single_grant got=%b/%0d exp=1/4", out_valid, select_bits);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL single_handshake got=%b/%h exp=0/0", out_valid, pending);
      end
   endtask

`ifndef ENCODER_ROUND_ROBIN_EN
   task automatic test_fixed_priority();
      logic [4:0] exp_sel [3];
      exp_sel[0] = 5'd1; exp_sel[1] = 5'd2; exp_sel[2] = 5'd31;
      out_ready = 1'b1;
      req_bits  = 32'h8000_0006;
      step();
      req_bits = 32'h0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || select_bits !== exp_sel[k]) begin
            errors++; $display("FAIL prio_grant%0d got=%b/%0d exp=1/%0d", k, out_valid, select_bits, exp_sel[k]);
         end
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++; $display("FAIL prio_gap%0d got=%b exp=0", k, out_valid);
         end
      end
      checks++;
      if (pending !== 32'h0) begin
         errors++; $display("FAIL prio_drained got=%h exp=0", pending);
      end
      out_ready = 1'b0;
   endtask
`endif

   task automatic test_hold();
      req_bits = 32'h0000_0008;
      step();
      req_bits = 32'h0;
      step();
      for (int k = 0; k < 5; k++) begin
         req_bits = (k % 2 == 0) ? 32'h1 : 32'h0;
         step();
         checks++;
         if (out_valid !== 1'b1 || select_bits !== 5'd3) begin
            errors++; $display("FAIL hold_cycle%0d got=%b/%0d exp=1/3", k, out_valid, select_bits);
         end
      end
      req_bits = 32'h0;
      checks++;
      if (pending !== 32'h0000_0009) begin
         errors++; $display("FAIL hold_pending got=%h exp=%h", pending, 32'h9);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h1) begin
         errors++; $display("FAIL hold_release got=%b/%h exp=0/1", out_valid, pending);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd0) begin
         errors++; $display("FAIL hold_next got=%b/%0d exp=1/0", out_valid, select_bits);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL hold_done got=%b/%h exp=0/0", out_valid, pending);
      end
   endtask

   task automatic test_set_wins();
      req_bits = 32'h0000_0080;
      step();
      req_bits = 32'h0;
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd7) begin
         errors++; $display("FAIL setwin_grant got=%b/%0d exp=1/7", out_valid, select_bits);
      end
      out_ready = 1'b1;
      req_bits  = 32'h0000_0080;
      step();
      req_bits = 32'h0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h80) begin
         errors++; $display("FAIL setwin_pending got=%b/%h exp=0/80", out_valid, pending);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd7) begin
         errors++; $display("FAIL setwin_regrant got=%b/%0d exp=1/7", out_valid, select_bits);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL setwin_done got=%b/%h exp=0/0", out_valid, pending);
      end
   endtask

   task automatic test_disabled();
      enabled  = 1'b0;
      req_bits = 32'hFFFF_FFFF;
      step(); step(); step();
      req_bits = 32'h0;
      checks++;
      if (pending !== 32'h0 || out_valid !== 1'b0 || select_bits !== 5'd7) begin
         errors++; $display("FAIL dis_ignore got=%h/%b/%0d exp=0/0/7", pending, out_valid, select_bits);
      end
      enabled  = 1'b1;
      req_bits = 32'h0000_0020;
      step();
      enabled  = 1'b0;
      req_bits = 32'h0;
      step();
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h20) begin
         errors++; $display("FAIL dis_no_grant got=%b/%h exp=0/20", out_valid, pending);
      end
      enabled = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd5) begin
         errors++; $display("FAIL dis_grant got=%b/%0d exp=1/5", out_valid, select_bits);
      end
      enabled   = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      enabled   = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h0) begin
         errors++; $display("FAIL dis_handshake got=%b/%h exp=0/0", out_valid, pending);
      end
   endtask

   task automatic test_edges();
      logic [31:0] vec [2];
      logic [4:0]  sel [2];
      vec[0] = 32'h8000_0000; sel[0] = 5'd31;
      vec[1] = 32'h0000_0001; sel[1] = 5'd0;
      for (int k = 0; k < 2; k++) begin
         req_bits = vec[k];
         step();
         req_bits = 32'h0;
         step();
         checks++;
         if (out_valid !== 1'b1 || select_bits !== sel[k]) begin
            errors++; $display("FAIL edge%0d got=%b/%0d exp=1/%0d", k, out_valid, select_bits, sel[k]);
         end
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset_mid_present();
      req_bits = 32'h0000_0300;
      step();
      req_bits = 32'h0;
      step();
      checks++;
      if (out_valid !== 1'b1 || select_bits !== 5'd8) begin
         errors++; $display("FAIL rstmid_grant got=%b/%0d exp=1/8", out_valid, select_bits);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || pending !== 32'h0 || select_bits !== 5'd0) begin
         errors++; $display("FAIL rstmid_drop got=%b/%h/%0d exp=0/0/0", out_valid, pending, select_bits);
      end
      step(); step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_lost got=%b exp=0", out_valid);
      end
   endtask

`ifdef ENCODER_ROUND_ROBIN_EN
   task automatic test_round_robin();
      logic [4:0] exp_sel [3];
      exp_sel[0] = 5'd1; exp_sel[1] = 5'd31; exp_sel[2] = 5'd0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      req_bits  = 32'h1;
      step();
      req_bits = 32'h0;
      step();
      step();
      req_bits = 32'h8000_0003;
      step();
      req_bits = 32'h0;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || select_bits !== exp_sel[k]) begin
            errors++; $display("FAIL rr_grant%0d got=%b/%0d exp=1/%0d", k, out_valid, select_bits, exp_sel[k]);
         end
         step();
      end
      out_ready = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
`ifndef ENCODER_ROUND_ROBIN_EN
      test_fixed_priority();
      test_hold();
      test_set_wins();
      test_disabled();
      test_edges();
`endif
      test_reset_mid_present();
`ifdef ENCODER_ROUND_ROBIN_EN
      test_round_robin();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
